// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Parses a framed host byte stream and writes 16-bit instruction
//            words into sequencer memory, holding the sequencer in reset
//            until the frame checksum verifies.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter logic [7:0] SYNC   = 8'hA5,
    parameter int         ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              head_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_WRITE = 3'd4,
        S_CHK   = 3'd5
    } state_t;

    // COUNT byte of zero selects a full-depth load
    localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rx_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic                r_head_rst;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W:0]     r_remaining;
    logic [7:0]          r_acc;
    logic                w_accept;
    logic                w_sync_hit;
    logic                w_chk_ok;

    assign w_accept   = rx_valid & r_rx_ready;
    assign w_sync_hit = w_accept && (r_state == S_IDLE) && (rx_data == SYNC);
    assign w_chk_ok   = w_accept && (r_state == S_CHK) && (rx_data == r_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_sync_hit) w_state_nxt = S_COUNT;
            S_COUNT: if (w_accept)   w_state_nxt = S_LO;
            S_LO:    if (w_accept)   w_state_nxt = S_HI;
            S_HI:    if (w_accept)   w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = (r_remaining == c_one) ? S_CHK : S_LO;
            S_CHK:   if (w_accept)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_ready  <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_head_rst  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_remaining <= '0;
            r_acc       <= '0;
        end else begin
            r_rx_ready <= (w_state_nxt != S_WRITE);
            r_we       <= (w_state_nxt == S_WRITE);
            r_done     <= w_chk_ok;
            case (r_state)
                S_IDLE: begin
                    if (w_sync_hit) begin
                        r_head_rst <= 1'b1;
                        r_err      <= 1'b0;
                        r_addr     <= '0;
                        r_acc      <= '0;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        r_remaining <= (rx_data == 8'd0) ? c_depth : (ADDR_W+1)'(rx_data);
                        r_acc       <= rx_data;
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        r_wdata[7:0] <= rx_data;
                        r_acc        <= r_acc ^ rx_data;
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        r_wdata[15:8] <= rx_data;
                        r_acc         <= r_acc ^ rx_data;
                    end
                end
                S_WRITE: begin
                    r_addr      <= r_addr + ADDR_W'(1);
                    r_remaining <= r_remaining - c_one;
                end
                S_CHK: begin
                    if (w_accept) begin
                        if (rx_data == r_acc) begin
                            r_head_rst <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign head_rst   = r_head_rst;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Brief    : Frame-level reference model bench for instr_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        head_rst;
    logic        done;
    logic        err;

    instr_loader #(.SYNC(8'hA5), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .head_rst   (head_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          obs_done = 0;
    bit          stall    = 0;
    logic        prev_done = 1'b0;
    logic [15:0] word_q[$];
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Checksum of a frame: COUNT xor every payload byte
    function automatic logic [7:0] model_chk(input logic [7:0] cnt);
        logic [7:0] c;
        c = cnt;
        foreach (word_q[k]) c = c ^ word_q[k][7:0] ^ word_q[k][15:8];
        return c;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                check("write_rx_ready_low", {31'd0, rx_ready}, 32'd0);
                check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", {24'd0, imem_addr}, {24'd0, e[23:16]});
                    check("write_data", {16'd0, imem_wdata}, {16'd0, e[15:0]});
                end
            end
            if (done) begin
                check("done_head_rst", {31'd0, head_rst}, 32'd0);
                check("done_width", {31'd0, prev_done}, 32'd0);
                obs_done++;
            end
        end
        prev_done = done;
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int gap;
        int guard;
        gap = stall ? int'($urandom_range(0, 3)) : 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        while (!rx_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            $display("FAIL ready_timeout: rx_ready stuck at 0, required 1 (t=%0t)", $time);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] cnt, input bit force_en, input logic [7:0] force_val);
        logic [7:0] good;
        logic [7:0] chk_b;
        bit         ok;
        good  = model_chk(cnt);
        chk_b = force_en ? force_val : good;
        ok    = (chk_b == good);
        foreach (word_q[k]) exp_q.push_back({8'(k), word_q[k]});
        obs_done = 0;
        send_byte(8'hA5);
        check("sync_err_clear", {31'd0, err}, 32'd0);
        check("sync_head_rst", {31'd0, head_rst}, 32'd1);
        send_byte(cnt);
        foreach (word_q[k]) begin
            send_byte(word_q[k][7:0]);
            send_byte(word_q[k][15:8]);
        end
        send_byte(chk_b);
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_count", obs_done, ok ? 32'd1 : 32'd0);
        check("frame_err", {31'd0, err}, ok ? 32'd0 : 32'd1);
        check("frame_head_rst", {31'd0, head_rst}, ok ? 32'd0 : 32'd1);
        check("frame_writes_left", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #13;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_wdata", {16'd0, imem_wdata}, 32'd0);
        check("rst_head_rst", {31'd0, head_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Two-word load
        word_q = '{16'h1003, 16'h2001};
        check("model_pin_2w", {24'd0, model_chk(8'h02)}, 32'h30);
        run_frame(8'h02, 1'b1, 8'h30);

        // Bad checksum
        run_frame(8'h02, 1'b1, 8'h31);

        // Garbage before sync, then a one-word frame (also clears err)
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        word_q = '{16'h0407};
        check("model_pin_1w", {24'd0, model_chk(8'h01)}, 32'h02);
        run_frame(8'h01, 1'b1, 8'h02);

        // Asynchronous reset between edges after a good frame
        #3 rst = 1'b1;
        #1;
        check("async_head_rst", {31'd0, head_rst}, 32'd1);
        check("async_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Full depth
        word_q.delete();
        for (int i = 0; i < 256; i++) word_q.push_back({~8'(i), 8'(i)});
        check("model_pin_full", {24'd0, model_chk(8'h00)}, 32'h00);
        run_frame(8'h00, 1'b0, 8'h00);

        // Stalled two-word load
        stall  = 1;
        word_q = '{16'h1003, 16'h2001};
        run_frame(8'h02, 1'b1, 8'h30);
        stall  = 0;

        // Abort after the first word is written
        exp_q.push_back({8'h00, 16'h1003});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h10);
        @(posedge clk); #1;
        check("abort_first_write", exp_q.size(), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_head_rst", {31'd0, head_rst}, 32'd1);
        check("abort_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("abort_we", {31'd0, imem_we}, 32'd0);
        check("abort_addr", {24'd0, imem_addr}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_frame(8'h02, 1'b1, 8'h30);

        // Random frames, some with corrupted checksums
        for (int it = 0; it < 15; it++) begin
            int  n;
            bit  bad;
            logic [7:0] cnt;
            n   = int'($urandom_range(1, 24));
            bad = ($urandom_range(0, 3) == 0);
            stall = $urandom_range(0, 1);
            cnt = 8'(n);
            word_q.delete();
            for (int k = 0; k < n; k++) word_q.push_back(16'($urandom));
            if (bad) run_frame(cnt, 1'b1, model_chk(cnt) ^ 8'($urandom_range(1, 255)));
            else     run_frame(cnt, 1'b0, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
# instr_loader

Host-side program loader that writes 16-bit instruction words into the sequencer's instruction memory. It parses a framed byte stream from the host and writes each assembled word to consecutive memory addresses from 0. While a load is in progress it holds the sequencer in reset, and releases it only after the frame's checksum verifies.

## Interface
Parameters:
- SYNC, 8'hA5, frame start byte
- ADDR_W, 8, instruction memory address width; depth is 2^ADDR_W

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  host byte valid
- rx_data  in  8  host byte
- rx_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  word; [7:0] opcode, [15:8] operand/weight address
- head_rst  out  1  sequencer reset request
- done  out  1  one-cycle pulse when a frame loads successfully
- err  out  1  sticky checksum-failure flag

## Operation
- Frame format: SYNC, COUNT, then COUNT word pairs (opcode byte, then address byte), then CHK.
- COUNT = 0 means 2^ADDR_W words; otherwise COUNT is the word count.
- CHK = XOR of COUNT and every payload byte. SYNC is not included.
- A byte transfers on a rising edge with rx_valid & rx_ready.
- State IDLE: rx_ready = 1. A byte equal to SYNC moves to COUNT, sets head_rst = 1, clears err, and resets the address and checksum accumulator to 0. Any other byte is discarded.
- State COUNT: latch the word count (ADDR_W+1-bit counter), seed the accumulator with COUNT, go to LO.
- State LO: latch the byte into wdata[7:0], XOR it into the accumulator, go to HI.
- State HI: latch the byte into wdata[15:8], XOR it into the accumulator, go to WRITE.
- State WRITE: rx_ready = 0 and imem_we = 1 for exactly one cycle. The address increments on exit and wraps modulo 2^ADDR_W. Decrement the remaining-word count; if it reaches 0 go to CHK, else go to LO.
- State CHK: on the checksum byte, go to IDLE.
  - Match: done pulses 1 cycle and head_rst deasserts.
  - Mismatch: err = 1 and head_rst stays 1.
- A SYNC value appearing inside the payload or as CHK is data; there is no resync mid-frame.
- A new SYNC accepted after a done returns the loader to loading and reasserts head_rst.
- Reset mid-frame aborts the load: state IDLE, all registers at reset values. Words already written stay in memory.

## Timing
- Reset values: rx_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, head_rst = 1, done = 0, err = 0, state = IDLE.
- head_rst stays 1 after reset until the first good frame completes.
- Write latency: imem_we is high in the cycle after the HI byte's accepting edge. imem_addr and imem_wdata are stable in that cycle.
- Throughput: at most 1 word per 3 cycles, since the WRITE state costs one stall cycle.
- done and the head_rst fall both occur in the cycle after the CHK accepting edge. done is high for exactly 1 cycle.
- Gaps in rx_valid hold the current state indefinitely; there is no timeout.
- All outputs are registered. rx_ready depends only on state.

## Test plan
- **Reset:** assert rst asynchronously between clock edges. Outputs go immediately to reset values (head_rst = 1, rx_ready = 1, others 0).
- **Two-word load:** bytes A5 02 03 10 01 20 30 with rx_valid continuous. Required response:
  - imem_we at addr 0 with wdata 16'h1003, then at addr 1 with 16'h2001;
  - rx_ready low in each write cycle;
  - done pulses once, head_rst falls, err stays 0.
- **Bad checksum:** same frame with CHK 31. Both words are written, err = 1, head_rst stays 1, no done pulse. A following A5 clears err.
- **Garbage before sync:** bytes 00 FF 5A, then a valid 1-word frame A5 01 07 04 02. Garbage produces no writes; one write of 16'h0407 at addr 0, then done.
- **Full depth:** COUNT 00 with 256 pairs (i, ~i). Required response:
  - 256 writes at addr 0..255 with wdata {~i, i};
  - CHK equals the XOR of all bytes, including COUNT 00, and done pulses.
- **Stalls and abort:** random rx_valid gaps give identical writes to the two-word case. Asserting rst after the first word is written leaves state IDLE and head_rst = 1; a full retransmitted frame then completes normally.
